// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, requester ids and the registered SRAM pin bundle.
package mem_arb_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} arb_state_t;
    typedef enum logic {PORT_LSU, PORT_IFU} port_id_t;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] dq;
        logic               dq_oe;
        logic               ce_n;
        logic               oe_n;
        logic               we_n;
        logic               lb_n;
        logic               ub_n;
    } sram_pins_t;

    function automatic sram_pins_t idle_pins();
        sram_pins_t p;
        p.addr  = '0;
        p.dq    = '0;
        p.dq_oe = 1'b0;
        p.ce_n  = 1'b1;
        p.oe_n  = 1'b1;
        p.we_n  = 1'b1;
        p.lb_n  = 1'b1;
        p.ub_n  = 1'b1;
        return p;
    endfunction

    // Pin values for one 16-bit half of a 32-bit access (half=0 is the low halfword).
    function automatic sram_pins_t phase_pins(
        input logic [SRAM_AW-2:0] word_addr,
        input logic               half,
        input logic               we,
        input logic [31:0]        wdata,
        input logic [3:0]         be
    );
        sram_pins_t p;
        p.addr  = {word_addr, half};
        p.ce_n  = 1'b0;
        p.oe_n  = we;
        p.we_n  = ~we;
        p.dq_oe = we;
        p.dq    = we ? (half ? wdata[31:16] : wdata[15:0]) : '0;
        p.lb_n  = we ? ~(half ? be[2] : be[0]) : 1'b0;
        p.ub_n  = we ? ~(half ? be[3] : be[1]) : 1'b0;
        return p;
    endfunction

endpackage

// File: rtl/sram_mem_arbiter.sv
// Shares one 256K x 16 SRAM between instruction fetch and load/store; each 32-bit
// access runs as a low then a high 16-bit phase, followed by a one-cycle ack.
module sram_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_STARVE  = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_lsu_req,
    input  logic                i_lsu_we,
    input  logic [31:0]         i_lsu_addr,
    input  logic [31:0]         i_lsu_wdata,
    input  logic [3:0]          i_lsu_be,
    output logic                o_lsu_ack,
    output logic [31:0]         o_lsu_rdata,
    input  logic                i_ifu_req,
    input  logic [31:0]         i_ifu_addr,
    output logic                o_ifu_ack,
    output logic [31:0]         o_ifu_rdata,
    output logic [SRAM_AW-1:0]  o_sram_addr,
    input  logic [SRAM_DW-1:0]  i_sram_dq,
    output logic [SRAM_DW-1:0]  o_sram_dq,
    output logic                o_sram_dq_oe,
    output logic                o_sram_ce_n,
    output logic                o_sram_oe_n,
    output logic                o_sram_we_n,
    output logic                o_sram_lb_n,
    output logic                o_sram_ub_n,
    output logic                o_busy
);

    localparam int PW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(WAIT_CYCLES);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    arb_state_t          state_reg;
    logic [PW-1:0]       phase_reg;
    logic [SW-1:0]       starve_reg;
    port_id_t            port_reg;
    logic [SRAM_AW-2:0]  addr_reg;
    logic                we_reg;
    logic [31:0]         wdata_reg;
    logic [3:0]          be_reg;
    logic [SRAM_DW-1:0]  rdata_lo_reg;
    sram_pins_t          pins_reg;
    logic                lsu_ack_reg;
    logic                ifu_ack_reg;
    logic [31:0]         lsu_rdata_reg;
    logic [31:0]         ifu_rdata_reg;

    logic                grant_ifu;
    logic                grant_we;
    logic [SRAM_AW-2:0]  grant_addr;
    logic [SW-1:0]       starve_next;

    // Only the word address inside the 512 KB window matters.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_lsu_addr[31:19], i_lsu_addr[1:0],
                                i_ifu_addr[31:19], i_ifu_addr[1:0]};

    // LSU normally wins; once it has won MAX_STARVE times in a row over a waiting IFU, IFU goes.
    always_comb begin
        grant_ifu   = i_ifu_req && (!i_lsu_req || starve_reg == STARVE_MAX);
        grant_addr  = grant_ifu ? i_ifu_addr[18:2] : i_lsu_addr[18:2];
        grant_we    = !grant_ifu && i_lsu_we;
        starve_next = starve_reg;
        if (grant_ifu || !i_ifu_req) begin
            starve_next = '0;
        end else if (starve_reg != STARVE_MAX) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            starve_reg    <= '0;
            port_reg      <= PORT_LSU;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            rdata_lo_reg  <= '0;
            pins_reg      <= idle_pins();
            lsu_ack_reg   <= 1'b0;
            ifu_ack_reg   <= 1'b0;
            lsu_rdata_reg <= '0;
            ifu_rdata_reg <= '0;
        end else begin
            lsu_ack_reg <= 1'b0;
            ifu_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_lsu_req || i_ifu_req) begin
                        port_reg   <= grant_ifu ? PORT_IFU : PORT_LSU;
                        addr_reg   <= grant_addr;
                        we_reg     <= grant_we;
                        wdata_reg  <= i_lsu_wdata;
                        be_reg     <= i_lsu_be;
                        starve_reg <= starve_next;
                        phase_reg  <= '0;
                        state_reg  <= LO;
                        pins_reg   <= phase_pins(grant_addr, 1'b0, grant_we, i_lsu_wdata, i_lsu_be);
                    end
                end
                LO: begin
                    if (phase_reg == PHASE_LAST) begin
                        rdata_lo_reg <= i_sram_dq;
                        phase_reg    <= '0;
                        state_reg    <= HI;
                        pins_reg     <= phase_pins(addr_reg, 1'b1, we_reg, wdata_reg, be_reg);
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                HI: begin
                    if (phase_reg == PHASE_LAST) begin
                        phase_reg <= '0;
                        state_reg <= DONE;
                        pins_reg  <= idle_pins();
                        if (port_reg == PORT_IFU) begin
                            ifu_ack_reg   <= 1'b1;
                            ifu_rdata_reg <= {i_sram_dq, rdata_lo_reg};
                        end else begin
                            lsu_ack_reg <= 1'b1;
                            if (!we_reg) begin
                                lsu_rdata_reg <= {i_sram_dq, rdata_lo_reg};
                            end
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_sram_addr  = pins_reg.addr;
    assign o_sram_dq    = pins_reg.dq;
    assign o_sram_dq_oe = pins_reg.dq_oe;
    assign o_sram_ce_n  = pins_reg.ce_n;
    assign o_sram_oe_n  = pins_reg.oe_n;
    assign o_sram_we_n  = pins_reg.we_n;
    assign o_sram_lb_n  = pins_reg.lb_n;
    assign o_sram_ub_n  = pins_reg.ub_n;
    assign o_lsu_ack    = lsu_ack_reg;
    assign o_lsu_rdata  = lsu_rdata_reg;
    assign o_ifu_ack    = ifu_ack_reg;
    assign o_ifu_rdata  = ifu_rdata_reg;
    assign o_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Bench for sram_mem_arbiter: an SRAM model on the pins, a transaction-level reference
// model checked every cycle, directed scenarios and randomized LSU/IFU traffic.
module tb_sram_mem_arbiter;

    localparam int W      = 1;
    localparam int P      = W + 1;
    localparam int MAXS   = 3;
    localparam int NWORDS = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [3:0]  lsu_be = '0;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        lsu_ack, ifu_ack, dq_oe, ce_n, oe_n, we_n, lb_n, ub_n, busy;
    logic [31:0] lsu_rdata, ifu_rdata;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rd;

    logic        ifu0_req = 1'b0;
    logic        d0_ifu_ack;
    logic        d0_unused_lsu_ack, d0_unused_dq_oe, d0_unused_ce, d0_unused_oe;
    logic        d0_unused_we, d0_unused_lb, d0_unused_ub, d0_unused_busy;
    logic [31:0] d0_unused_lsu_rdata, d0_unused_ifu_rdata;
    logic [17:0] d0_unused_addr;
    logic [15:0] d0_unused_dq;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_mem_arbiter #(.WAIT_CYCLES(W), .MAX_STARVE(MAXS)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_addr(lsu_addr),
        .i_lsu_wdata(lsu_wdata), .i_lsu_be(lsu_be),
        .o_lsu_ack(lsu_ack), .o_lsu_rdata(lsu_rdata),
        .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr),
        .o_ifu_ack(ifu_ack), .o_ifu_rdata(ifu_rdata),
        .o_sram_addr(sram_addr), .i_sram_dq(sram_rd), .o_sram_dq(sram_wdata),
        .o_sram_dq_oe(dq_oe), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
        .o_sram_we_n(we_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n),
        .o_busy(busy)
    );

    sram_mem_arbiter #(.WAIT_CYCLES(0), .MAX_STARVE(MAXS)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_lsu_req(1'b0), .i_lsu_we(1'b0), .i_lsu_addr(32'h0),
        .i_lsu_wdata(32'h0), .i_lsu_be(4'h0),
        .o_lsu_ack(d0_unused_lsu_ack), .o_lsu_rdata(d0_unused_lsu_rdata),
        .i_ifu_req(ifu0_req), .i_ifu_addr(32'h100),
        .o_ifu_ack(d0_ifu_ack), .o_ifu_rdata(d0_unused_ifu_rdata),
        .o_sram_addr(d0_unused_addr), .i_sram_dq(16'h0), .o_sram_dq(d0_unused_dq),
        .o_sram_dq_oe(d0_unused_dq_oe), .o_sram_ce_n(d0_unused_ce), .o_sram_oe_n(d0_unused_oe),
        .o_sram_we_n(d0_unused_we), .o_sram_lb_n(d0_unused_lb), .o_sram_ub_n(d0_unused_ub),
        .o_busy(d0_unused_busy)
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503 + 12345) ^ (i >> 5));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Physical SRAM on the DUT pins.
    logic [15:0] sram [NWORDS];
    assign sram_rd = (!ce_n && !oe_n) ? sram[sram_addr] : 16'h5A5A;
    initial begin
        for (int i = 0; i < NWORDS; i++) sram[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!ce_n && !we_n && dq_oe) begin
                if (!lb_n) sram[sram_addr][7:0]  = sram_wdata[7:0];
                if (!ub_n) sram[sram_addr][15:8] = sram_wdata[15:8];
            end
        end
    end

    // Reference model: memory contents and one transaction in flight, tracked by cycle offset.
    logic [15:0] ref_mem [NWORDS];
    bit          m_act = 0, m_ifu = 0, m_we = 0;
    int          m_k = 0, m_starve = 0;
    bit   [16:0] m_wa = '0;
    bit   [31:0] m_wd = '0, m_word = '0, m_lsu_rd = '0, m_ifu_rd = '0;
    bit   [3:0]  m_be = '0;
    initial begin
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_act = 0; m_k = 0; m_starve = 0; m_lsu_rd = '0; m_ifu_rd = '0;
            end else if (m_act) begin
                if (m_k == 2 * P) begin
                    m_act = 0;
                end else begin
                    m_k++;
                    if (m_k == 2 * P) begin
                        if (m_ifu) m_ifu_rd = m_word;
                        else if (!m_we) m_lsu_rd = m_word;
                    end
                end
            end else if (lsu_req || ifu_req) begin
                m_ifu    = ifu_req && (!lsu_req || m_starve == MAXS);
                m_starve = (m_ifu || !ifu_req) ? 0 : ((m_starve < MAXS) ? m_starve + 1 : MAXS);
                m_wa     = m_ifu ? ifu_addr[18:2] : lsu_addr[18:2];
                m_we     = !m_ifu && lsu_we;
                m_wd     = lsu_wdata;
                m_be     = lsu_be;
                m_word   = {ref_mem[{m_wa, 1'b1}], ref_mem[{m_wa, 1'b0}]};
                if (m_we) begin
                    if (m_be[0]) ref_mem[{m_wa, 1'b0}][7:0]  = m_wd[7:0];
                    if (m_be[1]) ref_mem[{m_wa, 1'b0}][15:8] = m_wd[15:8];
                    if (m_be[2]) ref_mem[{m_wa, 1'b1}][7:0]  = m_wd[23:16];
                    if (m_be[3]) ref_mem[{m_wa, 1'b1}][15:8] = m_wd[31:24];
                end
                m_act = 1;
                m_k   = 0;
            end
        end
    end

    // Per-cycle compare plus small logs used by the directed scenarios.
    bit          lsu_ack_s = 0, ifu_ack_s = 0;
    int          oe_low = 0;
    int          ntx = 0;
    bit          gq[$];
    logic [35:0] wlog[$];
    initial begin
        bit         ph, dn;
        int         half;
        logic [5:0] exp_str;
        forever begin
            @(negedge clk);
            ph = m_act && (m_k < 2 * P);
            dn = m_act && (m_k == 2 * P);
            half = (m_k >= P) ? 1 : 0;
            if (ph && m_we)
                exp_str = {1'b0, 1'b1, 1'b0, ~m_be[2 * half], ~m_be[2 * half + 1], 1'b1};
            else if (ph)
                exp_str = 6'b001000;
            else
                exp_str = 6'b111110;
            chk("strobes", {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, exp_str);
            chk("busy", busy, m_act);
            chk("lsu_ack", lsu_ack, dn && !m_ifu);
            chk("ifu_ack", ifu_ack, dn && m_ifu);
            chk("lsu_rdata", lsu_rdata, m_lsu_rd);
            chk("ifu_rdata", ifu_rdata, m_ifu_rd);
            if (ph) chk("sram_addr", sram_addr, {m_wa, half[0]});
            if (ph && m_we) chk("sram_dq", sram_wdata, half ? m_wd[31:16] : m_wd[15:0]);
            if (!oe_n) oe_low++;
            if (!we_n) wlog.push_back({sram_addr, sram_wdata, lb_n, ub_n});
            if (lsu_ack || ifu_ack) begin
                ntx++;
                gq.push_back(ifu_ack);
                $display("txn %0d port=%s word=%05h we=%0d rdata=%08h", ntx,
                         ifu_ack ? "IFU" : "LSU", m_wa, m_we, ifu_ack ? ifu_rdata : lsu_rdata);
            end
            lsu_ack_s = lsu_ack;
            ifu_ack_s = ifu_ack;
        end
    end

    task automatic ifu_txn(input logic [31:0] a, output int lat);
        ifu_addr = a;
        ifu_req  = 1'b1;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (ifu_ack_s) break;
            if (lat > 100) begin chk("ifu_timeout", lat, 0); break; end
        end
        ifu_req = 1'b0;
    endtask

    task automatic lsu_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int hold, output int lat);
        lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_be = be;
        lsu_req = 1'b1;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (hold > 0 && lat == hold) lsu_req = 1'b0;
            if (lsu_ack_s) break;
            if (lat > 100) begin chk("lsu_timeout", lat, 0); break; end
        end
        lsu_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int lat, n, cyc, last;
        logic [31:0] r;
        // Reset state.
        @(negedge clk);
        chk("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 6'b111110);
        chk("rst_addr_dq", {sram_addr, sram_wdata}, 34'h0);
        chk("rst_busy_acks", {busy, lsu_ack, ifu_ack}, 3'b000);
        chk("rst_rdata", {lsu_rdata, ifu_rdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2);

        // Zero-wait build: IFU held high gives an ack every 4 cycles.
        ifu0_req = 1'b1;
        n = 0; cyc = 0; last = -1;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (d0_ifu_ack) begin
                if (last >= 0) chk("w0_ack_gap", cyc - last, 4);
                last = cyc;
                n++;
            end
        end
        if (n < 4) chk("w0_ack_count", n, 4);
        ifu0_req = 1'b0;
        @(posedge clk); #1;

        // Single IFU read.
        sram[32'h40] = 16'h1234; ref_mem[32'h40] = 16'h1234;
        sram[32'h41] = 16'hABCD; ref_mem[32'h41] = 16'hABCD;
        oe_low = 0;
        ifu_txn(32'h0000_0080, lat);
        chk("ifu_latency", lat, 6);
        chk("ifu_word", ifu_rdata, 32'hABCD_1234);
        chk("ifu_oe_low_cycles", oe_low, 4);

        // LSU store with partial byte enables.
        sram[8] = 16'h0; ref_mem[8] = 16'h0;
        sram[9] = 16'h0; ref_mem[9] = 16'h0;
        wlog.delete();
        lsu_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0110, 0, lat);
        chk("st_latency", lat, 6);
        chk("st_wlog_len", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("st_lo_pins", wlog[0], {18'h00008, 16'hBEEF, 1'b1, 1'b0});
            chk("st_hi_pins", wlog[2], {18'h00009, 16'hDEAD, 1'b0, 1'b1});
        end
        chk("st_mem_lo", sram[8], 16'hBE00);
        chk("st_mem_hi", sram[9], 16'h00AD);
        chk("st_ref_mem", {ref_mem[9], ref_mem[8]}, 32'h00AD_BE00);
        chk("st_no_rdata", lsu_rdata, 32'h0);

        // Load back through ignored address bits, request dropped after one cycle.
        lsu_txn(1'b0, 32'hFFF8_0013, 32'h0, 4'h0, 1, lat);
        chk("ld_drop_latency", lat, 6);
        chk("ld_word", lsu_rdata, 32'h00AD_BE00);

        // Both requesters held high: LSU three times, then IFU.
        gq.delete();
        lsu_we = 1'b0; lsu_addr = 32'h20; ifu_addr = 32'h40;
        lsu_req = 1'b1; ifu_req = 1'b1;
        cyc = 0;
        while (gq.size() < 8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        lsu_req = 1'b0; ifu_req = 1'b0;
        chk("starve_len", gq.size(), 8);
        begin
            bit [7:0] exp_bits = 8'b1000_1000;
            for (int i = 0; i < 8 && i < gq.size(); i++) chk("starve_order", gq[i], exp_bits[i]);
        end
        idle_cycles(2);

        // Reset during the high phase aborts the access.
        ifu_addr = 32'h80; ifu_req = 1'b1;
        idle_cycles(3);
        chk("hi_phase_addr", sram_addr, 18'h00041);
        rst = 1'b1;
        #1;
        chk("arst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 6'b111110);
        chk("arst_busy_acks", {busy, lsu_ack, ifu_ack}, 3'b000);
        ifu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(3);
        ifu_txn(32'h0000_0080, lat);
        chk("post_rst_latency", lat, 6);
        chk("post_rst_word", ifu_rdata, 32'hABCD_1234);
        idle_cycles(1);

        // Randomized concurrent traffic over a small address window.
        fork
            begin
                int l;
                logic [31:0] a, d, rnd;
                for (int t = 0; t < 50; t++) begin
                    idle_cycles($urandom_range(0, 3));
                    rnd = $urandom;
                    a = ($urandom & 32'hFFF8_0003) | (32'($urandom_range(0, 15)) << 2);
                    d = $urandom;
                    lsu_txn(rnd[0], a, d, rnd[7:4], 0, l);
                end
            end
            begin
                int l;
                logic [31:0] a;
                for (int t = 0; t < 50; t++) begin
                    idle_cycles($urandom_range(0, 4));
                    a = ($urandom & 32'hFFF8_0003) | (32'($urandom_range(0, 15)) << 2);
                    ifu_txn(a, l);
                end
            end
        join
        idle_cycles(4);

        // Random stores must have landed in the SRAM exactly as the model says.
        for (int i = 0; i < 32; i++) chk("final_mem", sram[i], ref_mem[i]);

        r = 32'(errs);
        $display("Result: errors=%0d of %0d checks", r, checks);
        $finish;
    end

endmodule
